mem_port_arbiter: RTL and testbench

- Shares the single memory port between instruction fetch (read only) and the execute-stage load/store unit (read/write).
- Sits between the fetch stage, execute-stage ldst outputs and the memory macro.
- Serialises accesses, tracks the single outstanding read and routes returned data to its owner.
- Generates per-requester stall so the pipeline freezes while a request is pending.

---
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch / load-store arbiter for one memory port (optional ARB_ROUND_ROBIN_EN)
module mem_port_arbiter #(
  parameter int ADDR  = 16,
  parameter int W_OPR = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_req,
  input  logic [ADDR-1:0]  if_addr,
  output logic             if_rvalid,
  output logic [W_OPR-1:0] if_rdata,
  output logic             if_stall,
  input  logic             d_req,
  input  logic             d_write,
  input  logic [ADDR-1:0]  d_addr,
  input  logic [W_OPR-1:0] d_wdata,
  output logic             d_rvalid,
  output logic [W_OPR-1:0] d_rdata,
  output logic             d_stall,
  output logic             mem_req,
  output logic             mem_write,
  output logic [ADDR-1:0]  mem_addr,
  output logic [W_OPR-1:0] mem_wdata,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [W_OPR-1:0] mem_rdata
);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT_RD
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_FETCH,
    OWN_DATA
  } owner_t;

  state_t r_state;
  state_t w_state_nxt;
  owner_t r_owner;
  owner_t w_owner_nxt;

  logic w_sel_d;
  logic w_sel_if;
  logic w_accept;
  logic w_ret;
  logic w_d_wins_tie;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_d;

  // remember who won the last accepted request so a tie goes to the other side
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_d <= 1'b0;
    end else if (w_accept) begin
      r_last_d <= w_sel_d;
    end
  end

  assign w_d_wins_tie = ~r_last_d;
`else
  assign w_d_wins_tie = 1'b1;
`endif

  // pick which requester drives the port; only possible while no read is outstanding
  always_comb begin
    w_sel_d  = 1'b0;
    w_sel_if = 1'b0;
    if (r_state == ST_IDLE) begin
      if (d_req && (!if_req || w_d_wins_tie)) begin
        w_sel_d = 1'b1;
      end else if (if_req) begin
        w_sel_if = 1'b1;
      end
    end
  end

  // memory-side request mux; everything is zero when nobody is selected
  always_comb begin
    mem_req   = w_sel_d | w_sel_if;
    mem_write = w_sel_d & d_write;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_sel_d) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (w_sel_if) begin
      mem_addr  = if_addr;
    end
  end

  assign w_accept = mem_req & mem_gnt;
  assign w_ret    = (r_state == ST_WAIT_RD) & mem_rvalid;

  // next state: an accepted read parks us until its data returns; stores never leave IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && !mem_write) begin
          w_state_nxt = ST_WAIT_RD;
          w_owner_nxt = w_sel_d ? OWN_DATA : OWN_FETCH;
        end
      end
      ST_WAIT_RD: begin
        if (mem_rvalid) begin
          w_state_nxt = ST_IDLE;
          w_owner_nxt = OWN_NONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_owner_nxt = OWN_NONE;
      end
    endcase
  end

  // state and owner registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_owner <= OWN_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  // route returned read data to whoever issued it, plus the per-requester stalls
  always_comb begin
    if_rvalid = w_ret & (r_owner == OWN_FETCH);
    d_rvalid  = w_ret & (r_owner == OWN_DATA);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = d_rvalid ? mem_rdata : '0;
    if_stall  = if_req & ~if_rvalid;
    d_stall   = d_req & ~((w_accept & mem_write) | d_rvalid);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with random traffic and a memory responder
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_rvalid, if_stall;
  logic [15:0] if_addr;
  logic [31:0] if_rdata;
  logic        d_req, d_write, d_rvalid, d_stall;
  logic [15:0] d_addr;
  logic [31:0] d_wdata, d_rdata;
  logic        mem_req, mem_write, mem_gnt, mem_rvalid;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR(16), .W_OPR(32)) dut (
    .clk(clk), .reset(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
  } iss_t;

  iss_t        exp_iss[$];
  logic [31:0] exp_if[$];
  logic [31:0] exp_d[$];
  logic [15:0] rd_q[$];
  logic [31:0] mem_env[logic [15:0]];
  logic [31:0] ref_mem[logic [15:0]];

  int checks = 0;
  int errors = 0;
  int rv_count = 0;
  bit done_if, done_d, rd_acc, rd_out, slow_next, busy, last_d;

  function automatic logic [31:0] init_word(input logic [15:0] a);
    return {16'hC0DE ^ a, a};
  endfunction

  function automatic logic [31:0] env_rd(input logic [15:0] a);
    return mem_env.exists(a) ? mem_env[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event expected=none", name);
  endtask

  // monitor / scoreboard: sampled on the falling edge, away from the DUT's active edge
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check32("reset_ctrl", {26'b0, mem_req, mem_write, if_rvalid, d_rvalid, if_stall, d_stall}, 32'h0);
        check32("reset_addr", {16'b0, mem_addr}, 32'h0);
        check32("reset_data", mem_wdata | if_rdata | d_rdata, 32'h0);
      end else begin
        if (rd_out) check32("no_issue_while_busy", {31'b0, mem_req}, 32'h0);
        if (mem_req) begin
          if (exp_iss.size() == 0) begin
            fail_evt("unexpected_req");
          end else begin
            check32("req_write", {31'b0, mem_write}, {31'b0, exp_iss[0].wr});
            check32("req_addr", {16'b0, mem_addr}, {16'b0, exp_iss[0].addr});
            if (exp_iss[0].wr) check32("req_wdata", mem_wdata, exp_iss[0].wdata);
            if (mem_gnt) begin
              void'(exp_iss.pop_front());
              if (mem_write) begin
                mem_env[mem_addr] = mem_wdata;
              end else begin
                rd_q.push_back(mem_addr);
                rd_out = 1'b1;
                rd_acc = 1'b1;
              end
            end
          end
        end
        if (if_rvalid) begin
          rv_count++;
          rd_out = 1'b0;
          if (exp_if.size() == 0) fail_evt("spurious_if_rvalid");
          else check32("if_rdata", if_rdata, exp_if.pop_front());
        end
        if (d_rvalid) begin
          rv_count++;
          rd_out = 1'b0;
          if (exp_d.size() == 0) fail_evt("spurious_d_rvalid");
          else check32("d_rdata", d_rdata, exp_d.pop_front());
        end
        if (if_req && !if_stall) done_if = 1'b1;
        if (d_req && !d_stall) done_d = 1'b1;
      end
    end
  end

  // memory macro model: random grant, 1..3 cycle read latency, occasional spurious rvalid
  initial begin
    logic [15:0] r_addr;
    int          cnt;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    busy       = 1'b0;
    cnt        = 0;
    r_addr     = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (rst_n) begin
        if (!busy && rd_q.size() > 0) begin
          r_addr    = rd_q.pop_front();
          busy      = 1'b1;
          cnt       = slow_next ? 3 : int'($urandom_range(0, 2));
          slow_next = 1'b0;
        end
        if (busy) begin
          if (cnt == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = env_rd(r_addr);
            busy       = 1'b0;
          end else begin
            cnt--;
          end
        end else if ($urandom_range(0, 7) == 0) begin
          mem_rvalid = 1'b1;
        end
        mem_gnt = ($urandom_range(0, 3) != 0);
      end else begin
        mem_gnt = 1'b0;
      end
    end
  end

  // reference model: order of port issues and the value each read must return
  task automatic model_data(input logic [15:0] da, input bit wr, input logic [31:0] wd);
    if (wr) begin
      exp_iss.push_back({1'b1, da, wd});
      ref_mem[da] = wd;
    end else begin
      exp_iss.push_back({1'b0, da, 32'h0});
      exp_d.push_back(ref_rd(da));
    end
    last_d = 1'b1;
  endtask

  task automatic model_fetch(input logic [15:0] fa);
    exp_iss.push_back({1'b0, fa, 32'h0});
    exp_if.push_back(ref_rd(fa));
    last_d = 1'b0;
  endtask

  // kind: 0 fetch, 1 store, 2 load, 3 fetch+data together, 4 load dropped after issue (flush)
  task automatic run_txn(input int kind, input logic [15:0] fa, input logic [15:0] da,
                         input logic [31:0] wd, input bit dw);
    bit do_f, do_d, wr, data_first;
    int n;
    do_f       = (kind == 0) || (kind == 3);
    do_d       = (kind != 0);
    wr         = (kind == 1) || (kind == 3 && dw);
    data_first = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
    if (do_f && do_d) data_first = !last_d;
`endif
    if (do_d && data_first) model_data(da, wr, wd);
    if (do_f) model_fetch(fa);
    if (do_d && !data_first) model_data(da, wr, wd);
    @(posedge clk);
    #1;
    done_if = 1'b0;
    done_d  = 1'b0;
    rd_acc  = 1'b0;
    if_req  = do_f;
    if_addr = fa;
    d_req   = do_d;
    d_write = wr;
    d_addr  = da;
    d_wdata = wd;
    n = 0;
    if (kind == 4) begin
      while (!rd_acc && n < 60) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (!rd_acc) fail_evt("timeout_flush_accept");
      d_req = 1'b0;
      n = 0;
      while (exp_d.size() != 0 && n < 60) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (exp_d.size() != 0) fail_evt("timeout_flush_return");
    end else begin
      while ((if_req || d_req) && n < 60) begin
        @(posedge clk);
        #1;
        n++;
        if (done_if) if_req = 1'b0;
        if (done_d) d_req = 1'b0;
      end
      if (if_req || d_req) begin
        fail_evt("timeout_txn_complete");
        if_req = 1'b0;
        d_req  = 1'b0;
      end
    end
    d_write = 1'b0;
  endtask

  task automatic wait_resp_idle();
    int n;
    n = 0;
    while ((busy || rd_q.size() != 0) && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy || rd_q.size() != 0) fail_evt("timeout_responder_idle");
  endtask

  // reset while a fetch read is outstanding; the late return must not reach anyone
  task automatic reset_mid_read();
    int n, rv_before;
    slow_next = 1'b1;
    exp_iss.push_back({1'b0, 16'h0040, 32'h0});
    @(posedge clk);
    #1;
    rd_acc  = 1'b0;
    if_req  = 1'b1;
    if_addr = 16'h0040;
    n = 0;
    while (!rd_acc && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!rd_acc) fail_evt("timeout_reset_accept");
    if_req = 1'b0;
    rst_n  = 1'b0;
    exp_iss.delete();
    exp_if.delete();
    rd_out = 1'b0;
    last_d = 1'b0;
    rv_before = rv_count;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_resp_idle();
    repeat (3) @(posedge clk);
    #1;
    check32("rvalid_after_reset", 32'(rv_count - rv_before), 32'h0);
  endtask

  initial begin
    rst_n   = 1'b0;
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_write = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    last_d  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_txn(0, 16'h0010, 16'h0000, 32'h0, 1'b0);
    run_txn(1, 16'h0000, 16'h0100, 32'h12345678, 1'b1);
    run_txn(2, 16'h0000, 16'h0100, 32'h0, 1'b0);
    run_txn(3, 16'h0010, 16'h0200, 32'h0, 1'b0);
    run_txn(3, 16'h0100, 16'h0200, 32'h0, 1'b0);
    run_txn(3, 16'h0100, 16'h0100, 32'hCAFEF00D, 1'b1);
    run_txn(4, 16'h0000, 16'h0200, 32'h0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      run_txn(int'($urandom_range(0, 4)), 16'($urandom_range(0, 7) * 4),
              16'($urandom_range(0, 7) * 4), $urandom, 1'($urandom_range(0, 1)));
    end

    wait_resp_idle();
    reset_mid_read();

    for (int i = 0; i < 40; i++) begin
      run_txn(int'($urandom_range(0, 4)), 16'($urandom_range(0, 7) * 4),
              16'($urandom_range(0, 7) * 4), $urandom, 1'($urandom_range(0, 1)));
    end

    wait_resp_idle();
    repeat (3) @(posedge clk);
    check32("issue_queue_drained", 32'(exp_iss.size()), 32'h0);
    check32("if_queue_drained", 32'(exp_if.size()), 32'h0);
    check32("d_queue_drained", 32'(exp_d.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
